// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch sequencer for a single-issue core. It walks the program
// counter through a synchronous instruction memory (one cycle read latency),
// presents each fetched word to control decode, and reacts to stalls, taken
// branches and halt requests. It also counts retired instructions.
//
// Ports:
//   clk            single clock, all state updates on the rising edge
//   reset_n        synchronous active-low reset
//   start          begin or restart program execution (IDLE or HALT only)
//   stall          downstream cannot take the presented instruction
//   branch_taken   presented instruction resolved as a taken branch
//   branch_target  redirect address, qualified by branch_taken
//   halt_req       presented instruction is a halt
//   imem_rdata     instruction word, mem[addr] one cycle after imem_en
//   imem_addr      instruction memory address
//   imem_en        instruction memory read enable
//   instr          instruction presented to decode (imem_rdata)
//   instr_valid    instr/pc are meaningful this cycle
//   pc             address of the presented instruction
//   done           program halted
//   instr_count    instructions retired since the last start (saturating)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [9:0] START_PC = 10'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [9:0]  branch_target,
    input  logic        halt_req,
    input  logic [8:0]  imem_rdata,
    output logic [9:0]  imem_addr,
    output logic        imem_en,
    output logic [8:0]  instr,
    output logic        instr_valid,
    output logic [9:0]  pc,
    output logic        done,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        REDIRECT,
        HALT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [9:0]  pc_next;
    logic [15:0] count_next;
    logic        accept;

    // The memory returns data one cycle after the address, so the word sitting
    // on imem_rdata always belongs to the address issued in the previous
    // cycle. Decode simply sees that word directly.
    assign instr = imem_rdata;

    // Next-state and output decode.
    // pc is loaded with the address of the *next* instruction to present at
    // the moment a fetch of it is launched (start or taken branch). That way
    // FILL and REDIRECT just issue pc as the memory address, and the
    // following RUN cycle already shows the right pc without a separate
    // target register. While presenting an instruction, RUN prefetches pc+1;
    // a stall drops the read enable so the memory holds the current word.
    // Halt wins over a simultaneous taken branch.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        count_next  = instr_count;
        imem_addr   = pc;
        imem_en     = 1'b0;
        instr_valid = 1'b0;
        done        = 1'b0;
        accept      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FILL;
                    pc_next    = START_PC;
                    count_next = 16'd0;
                end
            end

            FILL: begin
                imem_en    = 1'b1;
                state_next = RUN;
            end

            RUN: begin
                instr_valid = 1'b1;
                imem_addr   = pc + 10'd1;
                imem_en     = ~stall;
                accept      = ~stall;
                if (accept) begin
                    if (instr_count != 16'hFFFF) begin
                        count_next = instr_count + 16'd1;
                    end
                    if (halt_req) begin
                        state_next = HALT;
                    end else if (branch_taken) begin
                        state_next = REDIRECT;
                        pc_next    = branch_target;
                    end else begin
                        pc_next = pc + 10'd1;
                    end
                end
            end

            REDIRECT: begin
                imem_en    = 1'b1;
                state_next = RUN;
            end

            HALT: begin
                done = 1'b1;
                if (start) begin
                    state_next = FILL;
                    pc_next    = START_PC;
                    count_next = 16'd0;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register. Reset wins over every other input and drops any
    // in-flight fetch: the machine goes back to IDLE and waits for start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= 10'd0;
            instr_count <= 16'd0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr_count <= count_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A behavioural instruction memory sits
// next to the DUT, and a program-level model tracks which instruction should
// be presented next, how many bubble cycles remain before it appears, and how
// many instructions have retired.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [9:0] START_PC = 10'd0;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [9:0]  branch_target;
    logic        halt_req;
    logic [8:0]  imem_rdata;
    logic [9:0]  imem_addr;
    logic        imem_en;
    logic [8:0]  instr;
    logic        instr_valid;
    logic [9:0]  pc;
    logic        done;
    logic [15:0] instr_count;

    logic [8:0]  mem [0:1023];

    int tests_run;
    int tests_failed;

    // Program-level reference: running means a program is in flight, gap is
    // the number of bubble cycles before the instruction at m_pc shows up,
    // halted means the last program ended on a halt.
    logic        m_running;
    logic        m_halted;
    int          m_gap;
    logic [9:0]  m_pc;
    logic [15:0] m_count;

    fetch_unit #(
        .START_PC (START_PC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .imem_rdata    (imem_rdata),
        .imem_addr     (imem_addr),
        .imem_en       (imem_en),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .done          (done),
        .instr_count   (instr_count)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous instruction memory: one cycle read latency, output held
    // while the read enable is low.
    always @(posedge clk) begin
        if (imem_en) begin
            imem_rdata <= mem[imem_addr];
        end
    end

    task automatic drive(input logic s, input logic st, input logic br,
                         input logic [9:0] tgt, input logic h);
        start         = s;
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        halt_req      = h;
    endtask

    // Advance one clock edge and update the program-level expectation from
    // the inputs the DUT sampled on that edge; returns 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (!reset_n) begin
            m_running = 1'b0;
            m_halted  = 1'b0;
            m_gap     = 0;
            m_pc      = 10'd0;
            m_count   = 16'd0;
        end else if (!m_running) begin
            if (start) begin
                m_running = 1'b1;
                m_halted  = 1'b0;
                m_gap     = 1;
                m_pc      = START_PC;
                m_count   = 16'd0;
            end
        end else if (m_gap > 0) begin
            m_gap = m_gap - 1;
        end else if (!stall) begin
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            if (halt_req) begin
                m_running = 1'b0;
                m_halted  = 1'b1;
            end else if (branch_taken) begin
                m_pc  = branch_target;
                m_gap = 1;
            end else begin
                m_pc = m_pc + 10'd1;
            end
        end
        #1;
    endtask

    // Reset, then start a program; returns in the cycle presenting START_PC.
    task automatic restart();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        tick();
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 10'h3FF, 1'b1);
        tick();
        tick();
        tests_run++;
        if (pc !== 10'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_pc: got %0h expected 0", pc);
        end
        tests_run++;
        if (imem_addr !== 10'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_imem_addr: got %0h expected 0", imem_addr);
        end
        tests_run++;
        if (imem_en !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_imem_en: got %0b expected 0", imem_en);
        end
        tests_run++;
        if (instr_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_instr_valid: got %0b expected 0", instr_valid);
        end
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_done: got %0b expected 0", done);
        end
        tests_run++;
        if (instr_count !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_instr_count: got %0d expected 0", instr_count);
        end
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
    endtask

    task automatic test_sequential();
        mem[0] = 9'h041;
        mem[1] = 9'h082;
        mem[2] = 9'h0C3;
        mem[3] = 9'h104;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        tick();
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        tests_run++;
        if (instr_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== START_PC) begin
            tests_failed++;
            $display("[TB] FAIL seq_fill: got valid=%0b en=%0b addr=%0h expected valid=0 en=1 addr=%0h",
                     instr_valid, imem_en, imem_addr, START_PC);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (instr_valid !== 1'b1 || pc !== 10'(i) || instr !== mem[i] || instr_count !== 16'(i)) begin
                tests_failed++;
                $display("[TB] FAIL seq_step%0d: got valid=%0b pc=%0h instr=%0h count=%0d expected valid=1 pc=%0h instr=%0h count=%0d",
                         i, instr_valid, pc, instr, instr_count, i, mem[i], i);
            end
        end
        tick();
        tests_run++;
        if (instr_count !== 16'd4) begin
            tests_failed++;
            $display("[TB] FAIL seq_count: got %0d expected 4", instr_count);
        end
    endtask

    task automatic test_stall();
        restart();
        tick();
        tick();
        drive(1'b0, 1'b1, 1'b1, 10'h123, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (pc !== 10'd2 || instr !== mem[2] || imem_en !== 1'b0 || instr_count !== 16'd2 || instr_valid !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL stall_cycle%0d: got pc=%0h instr=%0h en=%0b count=%0d valid=%0b expected pc=2 instr=%0h en=0 count=2 valid=1",
                         i, pc, instr, imem_en, instr_count, instr_valid, mem[2]);
            end
            if (i == 2) drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
            tick();
        end
        tests_run++;
        if (pc !== 10'd3 || instr !== mem[3] || instr_count !== 16'd3 || instr_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL stall_resume: got pc=%0h instr=%0h count=%0d valid=%0b expected pc=3 instr=%0h count=3 valid=1",
                     pc, instr, instr_count, instr_valid, mem[3]);
        end
    endtask

    task automatic test_branch();
        restart();
        for (int i = 0; i < 5; i++) tick();
        drive(1'b0, 1'b0, 1'b1, 10'h200, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        tests_run++;
        if (instr_valid !== 1'b0 || imem_addr !== 10'h200 || imem_en !== 1'b1 || instr_count !== 16'd6) begin
            tests_failed++;
            $display("[TB] FAIL branch_bubble: got valid=%0b addr=%0h en=%0b count=%0d expected valid=0 addr=200 en=1 count=6",
                     instr_valid, imem_addr, imem_en, instr_count);
        end
        tick();
        tests_run++;
        if (instr_valid !== 1'b1 || pc !== 10'h200 || instr !== mem[10'h200]) begin
            tests_failed++;
            $display("[TB] FAIL branch_target: got valid=%0b pc=%0h instr=%0h expected valid=1 pc=200 instr=%0h",
                     instr_valid, pc, instr, mem[10'h200]);
        end
        tick();
        tests_run++;
        if (pc !== 10'h201 || instr !== mem[10'h201] || instr_count !== 16'd7) begin
            tests_failed++;
            $display("[TB] FAIL branch_follow: got pc=%0h instr=%0h count=%0d expected pc=201 instr=%0h count=7",
                     pc, instr, instr_count, mem[10'h201]);
        end
    endtask

    task automatic test_halt_priority();
        restart();
        for (int i = 0; i < 7; i++) tick();
        drive(1'b0, 1'b0, 1'b1, 10'h100, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        tests_run++;
        if (done !== 1'b1 || instr_valid !== 1'b0 || imem_en !== 1'b0 || instr_count !== 16'd8) begin
            tests_failed++;
            $display("[TB] FAIL halt_enter: got done=%0b valid=%0b en=%0b count=%0d expected done=1 valid=0 en=0 count=8",
                     done, instr_valid, imem_en, instr_count);
        end
        tick();
        tick();
        tests_run++;
        if (done !== 1'b1 || instr_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL halt_hold: got done=%0b valid=%0b expected done=1 valid=0", done, instr_valid);
        end
        drive(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        tests_run++;
        if (done !== 1'b0 || instr_count !== 16'd0 || imem_en !== 1'b1 || imem_addr !== START_PC || instr_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL halt_restart_fill: got done=%0b count=%0d en=%0b addr=%0h valid=%0b expected done=0 count=0 en=1 addr=%0h valid=0",
                     done, instr_count, imem_en, imem_addr, instr_valid, START_PC);
        end
        tick();
        tests_run++;
        if (instr_valid !== 1'b1 || pc !== START_PC || instr !== mem[START_PC]) begin
            tests_failed++;
            $display("[TB] FAIL halt_restart_run: got valid=%0b pc=%0h instr=%0h expected valid=1 pc=%0h instr=%0h",
                     instr_valid, pc, instr, START_PC, mem[START_PC]);
        end
    endtask

    task automatic test_wrap_reset();
        restart();
        drive(1'b0, 1'b0, 1'b1, 10'h3FF, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        tick();
        tests_run++;
        if (instr_valid !== 1'b1 || pc !== 10'h3FF || instr !== mem[10'h3FF] || imem_addr !== 10'h000) begin
            tests_failed++;
            $display("[TB] FAIL wrap_top: got valid=%0b pc=%0h instr=%0h addr=%0h expected valid=1 pc=3ff instr=%0h addr=0",
                     instr_valid, pc, instr, imem_addr, mem[10'h3FF]);
        end
        tick();
        tests_run++;
        if (instr_valid !== 1'b1 || pc !== 10'h000 || instr !== mem[0]) begin
            tests_failed++;
            $display("[TB] FAIL wrap_zero: got valid=%0b pc=%0h instr=%0h expected valid=1 pc=0 instr=%0h",
                     instr_valid, pc, instr, mem[0]);
        end
        drive(1'b0, 1'b0, 1'b1, 10'h155, 1'b0);
        tick();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        tick();
        reset_n = 1'b1;
        tests_run++;
        if (pc !== 10'd0 || imem_addr !== 10'd0 || imem_en !== 1'b0 || instr_valid !== 1'b0 ||
            done !== 1'b0 || instr_count !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL redirect_reset: got pc=%0h addr=%0h en=%0b valid=%0b done=%0b count=%0d expected all 0",
                     pc, imem_addr, imem_en, instr_valid, done, instr_count);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (instr_valid !== 1'b0 || imem_en !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_idle%0d: got valid=%0b en=%0b expected valid=0 en=0", i, instr_valid, imem_en);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        tick();
        tests_run++;
        if (instr_valid !== 1'b1 || pc !== START_PC) begin
            tests_failed++;
            $display("[TB] FAIL reset_resume: got valid=%0b pc=%0h expected valid=1 pc=%0h", instr_valid, pc, START_PC);
        end
    endtask

    // Random mix of starts, stalls, branches, halts and occasional resets,
    // every cycle compared against the program-level model.
    task automatic test_random();
        logic s, st, br, h;
        logic [9:0] tgt;
        logic exp_valid;
        logic exp_gap;
        restart();
        for (int n = 0; n < 3000; n++) begin
            exp_valid = m_running && (m_gap == 0);
            exp_gap   = m_running && (m_gap > 0);
            tests_run++;
            if (instr_valid !== exp_valid || done !== m_halted || instr_count !== m_count) begin
                tests_failed++;
                $display("[TB] FAIL rand_state@%0d: got valid=%0b done=%0b count=%0d expected valid=%0b done=%0b count=%0d",
                         n, instr_valid, done, instr_count, exp_valid, m_halted, m_count);
            end
            if (exp_valid) begin
                tests_run++;
                if (pc !== m_pc || instr !== mem[m_pc]) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_instr@%0d: got pc=%0h instr=%0h expected pc=%0h instr=%0h",
                             n, pc, instr, m_pc, mem[m_pc]);
                end
            end
            s   = ($urandom_range(0, 19) == 0);
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 7) == 0);
            h   = ($urandom_range(0, 39) == 0);
            tgt = 10'($urandom);
            reset_n = ($urandom_range(0, 299) != 0);
            drive(s, st, br, tgt, h);
            #1;
            tests_run++;
            if (exp_valid) begin
                if (imem_en !== ~st || imem_addr !== m_pc + 10'd1) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_fetch@%0d: got en=%0b addr=%0h expected en=%0b addr=%0h",
                             n, imem_en, imem_addr, ~st, m_pc + 10'd1);
                end
            end else if (exp_gap) begin
                if (imem_en !== 1'b1 || imem_addr !== m_pc) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_fetch@%0d: got en=%0b addr=%0h expected en=1 addr=%0h",
                             n, imem_en, imem_addr, m_pc);
                end
            end else if (imem_en !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL rand_fetch@%0d: got en=%0b expected en=0", n, imem_en);
            end
            tick();
        end
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m_running    = 1'b0;
        m_halted     = 1'b0;
        m_gap        = 0;
        m_pc         = 10'd0;
        m_count      = 16'd0;
        imem_rdata   = 9'd0;
        reset_n      = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        for (int i = 0; i < 1024; i++) mem[i] = 9'($urandom);

        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_halt_priority();
        test_wrap_reset();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: START_PC, default 10'd0, first instruction address fetched after start.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  begin or restart program execution.
- stall  input  1  downstream cannot accept the presented instruction this cycle.
- branch_taken  input  1  decode/ALU resolved the presented instruction as a taken branch.
- branch_target  input  10  redirect address; valid with branch_taken.
- halt_req  input  1  presented instruction is a halt.
- imem_rdata  input  9  instruction word; equals mem[addr] one cycle after imem_en=1; held while imem_en=0.
- imem_addr  output  10  instruction memory address.
- imem_en  output  1  instruction memory read enable.
- instr  output  9  instruction presented to control decode; equals imem_rdata.
- instr_valid  output  1  instr/pc are meaningful this cycle.
- pc  output  10  address of presented instruction.
- done  output  1  program halted.
- instr_count  output  16  instructions retired since last start.

Function
REQ-003 States: IDLE, FILL, RUN, REDIRECT, HALT.
REQ-004 Accept condition: instruction retires in a cycle with state=RUN, instr_valid=1, stall=0.
REQ-005 IDLE: imem_en=0, instr_valid=0; start=1 -> FILL.
REQ-006 FILL: imem_addr=START_PC, imem_en=1, instr_valid=0; next cycle -> RUN with pc=START_PC.
REQ-007 RUN: instr_valid=1; imem_addr=pc+1 (mod 1024), imem_en=~stall.
REQ-008 RUN with stall=1: pc, imem_addr, state held; branch_taken and halt_req ignored; instr unchanged.
REQ-009 RUN, accept, no branch/halt: next cycle pc<=pc+1, imem_addr<=pc+2 (both mod 1024).
REQ-010 RUN, accept, branch_taken=1, halt_req=0: -> REDIRECT; REDIRECT drives imem_addr=branch_target, imem_en=1, instr_valid=0; next cycle -> RUN with pc=branch_target.
REQ-011 Taken branch costs exactly one bubble cycle; fetched data at old pc+1 is never presented valid.
REQ-012 RUN, accept, halt_req=1: -> HALT regardless of branch_taken (halt has priority).
REQ-013 HALT: done=1, imem_en=0, instr_valid=0; start=1 -> FILL (done cleared in FILL); otherwise stay.
REQ-014 start ignored in FILL, RUN, REDIRECT.
REQ-015 pc wraps 10'h3FF -> 10'h000 with no flag.
REQ-016 instr_count increments by 1 per accept, including the branch and halt instruction; saturates at 16'hFFFF; cleared to 0 on the cycle start is accepted.
REQ-017 branch_taken, halt_req, stall ignored whenever instr_valid=0.

Reset
REQ-018 reset_n=0 at rising edge: state=IDLE, pc=0, imem_addr=0, imem_en=0, instr_valid=0, done=0, instr_count=0; takes priority over all inputs.
REQ-019 Reset mid-RUN/REDIRECT abandons in-flight fetch; no valid instruction presented until next start.
REQ-020 instr output value unconstrained while instr_valid=0.

Verification
REQ-021 Sequential: mem[0..3]=9'h041,9'h082,9'h0C3,9'h104, start pulse -> FILL 1 cycle, then pc=0,1,2,3 on consecutive cycles with instr matching, instr_count=4 after cycle presenting pc=3.
REQ-022 Stall: stall=1 for 3 cycles while pc=2 -> pc=2, instr constant, imem_en=0 for 3 cycles, instr_count unchanged; resumes pc=3.
REQ-023 Branch: branch_taken=1, branch_target=10'h200 at pc=5 -> next cycle instr_valid=0, imem_addr=10'h200; following cycle pc=10'h200, instr=mem[10'h200].
REQ-024 Halt priority: halt_req=1 and branch_taken=1 at pc=7 -> HALT, done=1, instr_count includes pc=7; later start -> FILL, pc=START_PC, instr_count=0.
REQ-025 Wrap/reset: branch to 10'h3FF -> next presented pc=10'h000; reset_n=0 during REDIRECT -> all outputs 0 next cycle, start required to resume.
